// File: rtl/isa_types.sv
`default_nettype none
// ============================================================================
// Package     : isa_types
// Description : Shared ISA-level types and constants: register width, store
//               width encoding and the memory read latency used at
//               instantiation of the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package isa_types;

    localparam int XLEN = 32;

    // Store width seen by the memory; the all-zero encoding is the reset value.
    typedef enum logic [1:0] {
        WW_BYTE = 2'd0,
        WW_HALF = 2'd1,
        WW_WORD = 2'd2
    } write_width_t;

    // Memory cycles from address presentation to valid read data.
    localparam int MEM_READ_LATENCY = 1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter. Grant is combinational and
//               one-hot; on a tie the requester not granted last wins. The
//               last-grant register only moves when the caller accepts the
//               grant (i_grant_en) and somebody was actually requesting.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic [1:0] o_grant
);

    // 1 when requester 1 holds the most recent grant (so requester 0 wins ties)
    logic r_last_hi;

    // Pick the sole requester, or on a tie the one not granted last
    always_comb begin
        o_grant = 2'b00;
        if (i_req[0] && (!i_req[1] || r_last_hi)) begin
            o_grant = 2'b01;
        end else if (i_req[1]) begin
            o_grant = 2'b10;
        end
    end

    // Remember who won the last accepted grant; reset favours requester 0 next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_hi <= 1'b1;
        end else if (i_grant_en && (|i_req)) begin
            r_last_hi <= o_grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one synchronous memory port between an instruction
//               fetch requester and a load/store requester. Requests are
//               sampled only when idle, the winner's access is held on the
//               memory bus for READ_LATENCY cycles, then a single-cycle ack
//               is returned to that requester.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import isa_types::*;
#(
    parameter int READ_LATENCY = MEM_READ_LATENCY
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_ack,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_wenable,
    input  write_width_t    d_wwidth,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic [XLEN-1:0] mem_addr,
    output write_width_t    mem_wwidth,
    output logic            mem_wenable,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    localparam logic [2:0] c_LAT = 3'(READ_LATENCY);

    typedef enum logic {
        SEL_FETCH = 1'b0,
        SEL_DATA  = 1'b1
    } sel_t;

    logic [1:0]   r_state;
    logic [2:0]   r_count;
    sel_t         r_sel;
    logic         r_if_ack;
    logic         r_d_ack;
    logic         r_busy;
    logic         r_mem_wenable;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    write_width_t r_mem_wwidth;

    logic [1:0]   w_grant;
    logic         w_grant_en;

    // Ties are only resolved while idle; that is also when the winner is latched
    assign w_grant_en = (r_state == c_IDLE);

    rr_arbiter2 u_rr (
        .clk        (clock),
        .rst        (reset),
        .i_req      ({d_req, if_req}),
        .i_grant_en (w_grant_en),
        .o_grant    (w_grant)
    );

    // Grant, hold the access for READ_LATENCY cycles, then ack the winner once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= c_IDLE;
            r_count       <= 3'd0;
            r_sel         <= SEL_DATA;
            r_if_ack      <= 1'b0;
            r_d_ack       <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_wenable <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_wwidth  <= WW_BYTE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    if (w_grant[1]) begin
                        r_state       <= c_ACCESS;
                        r_busy        <= 1'b1;
                        r_count       <= c_LAT;
                        r_sel         <= SEL_DATA;
                        r_mem_addr    <= d_addr;
                        r_mem_wdata   <= d_wdata;
                        r_mem_wwidth  <= d_wwidth;
                        r_mem_wenable <= d_wenable;
                    end else if (w_grant[0]) begin
                        // Fetches never write; store fields keep their last values
                        r_state       <= c_ACCESS;
                        r_busy        <= 1'b1;
                        r_count       <= c_LAT;
                        r_sel         <= SEL_FETCH;
                        r_mem_addr    <= if_addr;
                        r_mem_wenable <= 1'b0;
                    end
                end
                c_ACCESS: begin
                    // The write strobe lives only in the first access cycle
                    r_mem_wenable <= 1'b0;
                    r_count       <= r_count - 3'd1;
                    if (r_count == 3'd1) begin
                        r_state  <= c_DONE;
                        r_if_ack <= (r_sel == SEL_FETCH);
                        r_d_ack  <= (r_sel == SEL_DATA);
                    end
                end
                c_DONE: begin
                    r_state  <= c_IDLE;
                    r_busy   <= 1'b0;
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                end
                default: begin
                    r_state       <= c_IDLE;
                    r_busy        <= 1'b0;
                    r_if_ack      <= 1'b0;
                    r_d_ack       <= 1'b0;
                    r_mem_wenable <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack      = r_if_ack;
    assign d_ack       = r_d_ack;
    assign busy        = r_busy;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_wwidth  = r_mem_wwidth;
    assign mem_wenable = r_mem_wenable;

    // Read data is only meaningful alongside the matching ack
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: READ_LATENCY, default 1, memory cycles from address presentation to valid rdata (legal 1..4).
REQ-002 SHALL have ports (name  direction  width  meaning):
  clock  in  1  single clock, all state on rising edge
  reset  in  1  asynchronous, active-high reset
  if_req  in  1  instruction-fetch read request, held until if_ack
  if_addr  in  XLEN  fetch byte address
  if_ack  out  1  one-cycle pulse, fetch complete
  if_rdata  out  XLEN  fetch data, valid while if_ack
  d_req  in  1  data request, held until d_ack
  d_wenable  in  1  data request is a store
  d_wwidth  in  write_width_t  store width
  d_addr  in  XLEN  data byte address
  d_wdata  in  XLEN  store data
  d_ack  out  1  one-cycle pulse, load/store complete
  d_rdata  out  XLEN  load data, valid while d_ack
  mem_addr  out  XLEN  to memory addr
  mem_wwidth  out  write_width_t  to memory wwidth
  mem_wenable  out  1  to memory wenable
  mem_wdata  out  XLEN  to memory wdata
  mem_rdata  in  XLEN  from memory rdata
  busy  out  1  access in progress (state != IDLE)

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; requests sampled only in IDLE.
REQ-004 SHALL, in IDLE with any req high, grant one requester and latch its addr/wenable/wwidth/wdata on that edge; IDLE with no req stays IDLE.
REQ-005 SHALL grant the sole requester when only one req is high.
REQ-006 SHALL, when both req high, grant the requester not granted last (round-robin); after reset the last-granted is data, so fetch wins first tie.
REQ-007 SHALL remain in ACCESS exactly READ_LATENCY cycles via down-counter (3 bits), then enter DONE.
REQ-008 SHALL drive mem_addr/mem_wwidth/mem_wdata from latched values throughout ACCESS and DONE; hold last values in IDLE.
REQ-009 SHALL assert mem_wenable only in the first ACCESS cycle of a granted store; 0 at all other times, never for fetches.
REQ-010 SHALL assert exactly one of if_ack/d_ack (granted requester) for the single DONE cycle, for loads and stores alike.
REQ-011 SHALL drive if_rdata and d_rdata combinationally from mem_rdata (meaningful only with the matching ack).
REQ-012 SHALL give access latency READ_LATENCY+2 cycles from grant-sample cycle to ack cycle inclusive (3 for default): grant cycle 0, ACCESS 1..L, DONE L+1.
REQ-013 SHALL complete a granted access and pulse ack even if the requester drops req after grant; a req dropped before grant is never served.
REQ-014 SHALL treat a req still high in the IDLE cycle after DONE as a new request (requesters must drop req on ack).
REQ-015 SHALL pass stores to ROM addresses unchanged; memory decode ignores them, ack still issued.

Reset
REQ-016 SHALL on reset asynchronously force: state IDLE, counter 0, last-granted = data, if_ack 0, d_ack 0, mem_wenable 0, busy 0, mem_addr 0, mem_wdata 0, mem_wwidth all-zero encoding.
REQ-017 SHALL abandon any in-flight access on reset with no ack; a store whose ACCESS cycle was already passed remains written.
REQ-018 SHALL sample first request on the first rising edge after reset deasserts.

Structure
REQ-019 SHALL take XLEN and write_width_t from isa_types; constant MEM_READ_LATENCY (=1) SHALL be added to isa_types as the instantiation value.
REQ-020 SHALL keep FSM state enum and requester-select type local to the module.
REQ-021 SHALL factor tie-break into one sub-module rr_arbiter2 (two req in, one-hot grant out, last-grant register updated on grant-enable).

Verification
REQ-022 Reset, if_req=1, if_addr=0x010, memory word 0x00000013 -> mem_addr=0x010 from cycle 1, if_ack=1 in cycle 2 with if_rdata=0x00000013, d_ack never.
REQ-023 d_req store d_addr=0x804 d_wdata=0xDEADBEEF full word -> mem_wenable=1 one cycle only; subsequent load 0x804 gives d_rdata=0xDEADBEEF at its ack.
REQ-024 if_req and d_req held high together from reset -> grants alternate fetch, data, fetch, data; one ack per 3 cycles, none concurrent.
REQ-025 READ_LATENCY=3, fetch 0x020 -> ACCESS 3 cycles, if_ack in cycle 4, busy high cycles 1..4.
REQ-026 Reset asserted mid-ACCESS of store to 0x808 -> acks, mem_wenable, busy 0 immediately; after release next tie grants fetch.
